// File: rtl/fifo_mem.sv
// Storage stage of the synchronous FIFO: circular buffer with registered read data,
// occupancy count, registered status flags and one-cycle overflow/underflow pulses.
module fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    mem_wr_en,
   input  logic [DATA_WIDTH-1:0]   mem_wr_data,
   input  logic                    mem_rd_en,
   output logic [DATA_WIDTH-1:0]   mem_rd_data,
   output logic                    mem_rd_valid,
   output logic                    mem_full,
   output logic                    mem_empty,
   output logic                    mem_almost_full,
   output logic                    mem_almost_empty,
   output logic                    mem_wr_err,
   output logic                    mem_rd_err,
   output logic [$clog2(DEPTH):0]  mem_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] ONE_CNT  = CW'(1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [DATA_WIDTH-1:0] mem_array_reg [DEPTH];

   logic [CW-1:0]         wr_ptr_reg, wr_ptr_next;
   logic [CW-1:0]         rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]         count_reg, count_next;
   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic                  rd_valid_reg;
   logic                  wr_err_reg, rd_err_reg;
   logic                  full_reg, empty_reg;
   logic                  almost_full_reg, almost_empty_reg;
   logic                  wr_ok, rd_ok;
   logic [AW-1:0]         wr_idx, rd_idx;

   // Acceptance uses only registered flags, so no input reaches a status output combinationally.
   always_comb begin
      wr_ok       = mem_wr_en & ~full_reg;
      rd_ok       = mem_rd_en & ~empty_reg;
      wr_idx      = wr_ptr_reg[AW-1:0];
      rd_idx      = rd_ptr_reg[AW-1:0];
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (wr_ok) begin
         wr_ptr_next = wr_ptr_reg + ONE_CNT;
      end
      if (rd_ok) begin
         rd_ptr_next = rd_ptr_reg + ONE_CNT;
      end
      unique case ({wr_ok, rd_ok})
         2'b10:   count_next = count_reg + ONE_CNT;
         2'b01:   count_next = count_reg - ONE_CNT;
         default: count_next = count_reg;
      endcase
   end

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem_array_reg[wr_idx] <= mem_wr_data;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         rd_data_reg      <= '0;
         rd_valid_reg     <= 1'b0;
         wr_err_reg       <= 1'b0;
         rd_err_reg       <= 1'b0;
         full_reg         <= 1'b0;
         empty_reg        <= 1'b1;
         almost_full_reg  <= 1'b0;
         almost_empty_reg <= 1'b1;
      end else begin
         wr_ptr_reg       <= wr_ptr_next;
         rd_ptr_reg       <= rd_ptr_next;
         count_reg        <= count_next;
         rd_valid_reg     <= rd_ok;
         wr_err_reg       <= mem_wr_en & full_reg;
         rd_err_reg       <= mem_rd_en & empty_reg;
         full_reg         <= (count_next == FULL_CNT);
         empty_reg        <= (count_next == '0);
         almost_full_reg  <= (count_next >= AF_CNT);
         almost_empty_reg <= (count_next <= AE_CNT);
         if (rd_ok) begin
            rd_data_reg <= mem_array_reg[rd_idx];
         end
      end
   end

   assign mem_rd_data      = rd_data_reg;
   assign mem_rd_valid     = rd_valid_reg;
   assign mem_full         = full_reg;
   assign mem_empty        = empty_reg;
   assign mem_almost_full  = almost_full_reg;
   assign mem_almost_empty = almost_empty_reg;
   assign mem_wr_err       = wr_err_reg;
   assign mem_rd_err       = rd_err_reg;
   assign mem_count        = count_reg;

endmodule

// File: doc/fifo_mem.md
Name: fifo_mem

Overview:
- Storage stage of the synchronous FIFO, directly downstream of the read- and write-control stages.
- Consumes registered mem_wr_en / mem_rd_en strobes and holds data in a circular buffer.
- Returns data plus status (mem_full, mem_empty, mem_wr_err, mem_rd_err); the control stages register these status outputs again toward the FIFO boundary.

Parameters:
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; must be a power of two, minimum 4
- AF_LEVEL, DEPTH-2, count at or above which mem_almost_full asserts
- AE_LEVEL, 2, count at or below which mem_almost_empty asserts

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- mem_wr_en  in  1  write request, one word per cycle
- mem_wr_data  in  DATA_WIDTH  write data, sampled with mem_wr_en
- mem_rd_en  in  1  read request, one word per cycle
- mem_rd_data  out  DATA_WIDTH  read data, registered
- mem_rd_valid  out  1  mem_rd_data holds a newly popped word this cycle
- mem_full  out  1  count == DEPTH
- mem_empty  out  1  count == 0
- mem_almost_full  out  1  count >= AF_LEVEL
- mem_almost_empty  out  1  count <= AE_LEVEL
- mem_wr_err  out  1  write rejected (overflow attempt), one-cycle pulse
- mem_rd_err  out  1  read rejected (underflow attempt), one-cycle pulse
- mem_count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async on nRST low, all outputs held while low):
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - mem_rd_data = 0, mem_rd_valid = 0, mem_wr_err = 0, mem_rd_err = 0
  - mem_empty = 1, mem_almost_empty = 1, mem_full = 0, mem_almost_full = 0
  - Storage array contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - The array is indexed by the low bits and wraps naturally from DEPTH-1 to 0.
- Write acceptance, evaluated on the current-cycle state before the edge:
  - wr_ok = mem_wr_en & ~mem_full.
  - When wr_ok: array[wr_ptr] <= mem_wr_data, wr_ptr increments.
- Read acceptance:
  - rd_ok = mem_rd_en & ~mem_empty.
  - When rd_ok: mem_rd_data <= array[rd_ptr], rd_ptr increments, mem_rd_valid <= 1; otherwise mem_rd_valid <= 0.
  - mem_rd_data holds its last value when no read is accepted.
  - Read latency: data appears in the cycle after the edge on which mem_rd_en was sampled.
- Count update per edge:
  - +1 on wr_ok only
  - -1 on rd_ok only
  - unchanged when both or neither are accepted
- Simultaneous read and write:
  - When full: read accepted, write rejected, mem_wr_err pulses, count becomes DEPTH-1. No bypass.
  - When empty: write accepted, read rejected, mem_rd_err pulses, count becomes 1. The written word is not forwarded to mem_rd_data.
  - Otherwise: both accepted, count unchanged, and the read returns the oldest word.
- Errors:
  - mem_wr_err <= mem_wr_en & mem_full
  - mem_rd_err <= mem_rd_en & mem_empty
  - Both are registered pulses asserted for one cycle per rejected request.
  - A rejected request changes no pointer, count, or data.
- Flags:
  - mem_full, mem_empty, mem_almost_full and mem_almost_empty are decoded from the registered count, with no combinational path from inputs.
  - mem_count is always consistent with (wr_ptr - rd_ptr).
- Reset mid-operation: asserting nRST with the FIFO partially filled returns it immediately to the empty reset state. The next write after release lands at array[0].

Test Plan:
- Reset then idle 5 cycles -> mem_empty=1, mem_almost_empty=1, mem_count=0, mem_rd_valid=0, no error pulses.
- Write 0x01..0x10 (16 words, DEPTH=16), then read 16 -> mem_full=1 after 16th write; mem_almost_full=1 from count 14; reads return 0x01..0x10 in order, each one cycle after mem_rd_en; mem_empty=1 after last read.
- Fill to 16, then assert mem_wr_en with data 0xAA -> mem_wr_err pulses 1 cycle, mem_count stays 16; a subsequent full drain never returns 0xAA.
- From empty, mem_rd_en and mem_wr_en (0x55) together -> mem_rd_err pulses, mem_rd_valid=0, mem_count=1; next read returns 0x55.
- Full FIFO with simultaneous read and write (0x77) -> read returns oldest word, mem_wr_err=1, mem_count=15.
- Write 10, read 10, write 10 (pointer wrap), and pull nRST low for 1 cycle with mem_count=6 -> data order preserved across the wrap; after reset mem_count=0, mem_empty=1, and the next write/read pair returns the new word.
